mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage with integrated MEM/WB register. It consumes the EX/MEM register outputs and performs loads and stores on a word-addressed data memory with a configurable multi-cycle latency. It then registers the write-back bundle for the WB stage. While a memory operation is in flight it drives `mem_stall` so the upstream stages freeze.

## Interface
- `DEPTH_WORDS`, 256, data memory size in 32-bit words; power of two, ≥2.
- `MEM_LATENCY`, 2, cycles a load/store occupies the stage; 1..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high.
- `ALUResult_in` input 32: byte address for memory ops; pass-through result otherwise.
- `WriteData_in` input 32: store data.
- `WriteReg_in` input 5: destination register.
- `RegWrite_in`, `MemtoReg_in`, `MemRead_in`, `MemWrite_in` input 1 each: control from EX/MEM.
- `mem_stall` output 1: combinational; high = EX/MEM and earlier stages must hold.
- `ReadData_out` output 32: load data to WB.
- `ALUResult_out` output 32, `WriteReg_out` output 5, `RegWrite_out` output 1, `MemtoReg_out` output 1: MEM/WB bundle.
- `align_fault` output 1: one-cycle pulse; present only with the macro in Configuration.

## Operation
- Memory op = `MemRead_in | MemWrite_in`. When both are set, the op is a store; `ReadData_out` is loaded with 0.
- Word index = `ALUResult_in[log2(DEPTH_WORDS)+1:2]`. Higher bits are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.
- FSM states:
  - **IDLE**:
    - Non-memory op: MEM/WB loads the inputs each edge; `ReadData_out` is loaded with 0.
    - Memory op with `MEM_LATENCY==1`: completes at this edge.
    - Memory op with `MEM_LATENCY>1`: go to BUSY with `cnt <= MEM_LATENCY-2`; MEM/WB loads a bubble.
  - **BUSY**:
    - `cnt!=0`: `cnt` decrements; MEM/WB loads a bubble.
    - `cnt==0`: completes the op; go to IDLE.
- Bubble = `RegWrite_out=0`, `MemtoReg_out=0`. `ALUResult_out`, `WriteReg_out` and `ReadData_out` hold their values.
- Completion edge:
  - Store: writes `WriteData_in` to `mem[index]`.
  - Load: loads `ReadData_out <= mem[index]`.
  - In both cases MEM/WB loads `ALUResult_in`, `WriteReg_in`, `RegWrite_in` and `MemtoReg_in`.
- `mem_stall = (IDLE & memop & MEM_LATENCY>1) | (BUSY & cnt!=0)`.
- Upstream holds EX/MEM inputs stable while `mem_stall=1`. The block samples the inputs only at the completion edge.
- Memory contents are not cleared by reset; simulation initialises them to 0.

## Timing
- Reset (asynchronous):
  - State IDLE, `cnt=0`.
  - All registered outputs = 0; `align_fault=0`.
  - An in-flight store is discarded and memory is left unchanged.
- Non-memory op: 1 cycle, no stall.
- Memory op:
  - Occupies exactly `MEM_LATENCY` cycles.
  - `mem_stall` is high for the first `MEM_LATENCY-1` cycles and low in the last.
  - Result is visible on the MEM/WB outputs the cycle after completion.
- Load following a store to the same address: the store completes first, so the load returns the new data.
- Back-to-back memory ops: the next op is presented in the cycle after completion and starts immediately from IDLE, with no dead cycle.

## Configuration
- Macro: `MEM_STAGE_ALIGN_CHECK_EN`.
- Defined:
  - A memory op with `ALUResult_in[1:0]!=0` still takes `MEM_LATENCY` cycles.
  - At completion the store write is suppressed; a load returns 0 and forces `RegWrite_out=0`.
  - `align_fault` pulses high for 1 cycle after the completion edge.
- Undefined: `align_fault` port is absent; `ALUResult_in[1:0]` is ignored.

## Test plan
- Reset held, then released with non-memory op `ALUResult_in=0x1234`, `WriteReg_in=5`, `RegWrite_in=1` → all outputs 0 during reset; next edge gives `ALUResult_out=0x1234`, `WriteReg_out=5`, `RegWrite_out=1`; `mem_stall` never high.
- `MEM_LATENCY=3`, store `0xDEADBEEF` to addr 0x40 → `mem_stall` high 2 cycles; MEM/WB shows 2 bubbles.
- Load from 0x40 immediately after that store → after 3 cycles `ReadData_out=0xDEADBEEF`, `MemtoReg_out=1`.
- Load from addr `0x40 + DEPTH_WORDS*4` → returns `0xDEADBEEF` (wrap).
- Assert `reset` in the BUSY cycle of a store to 0x80 → outputs 0, state IDLE; a later load of 0x80 returns 0.
- With `MEM_STAGE_ALIGN_CHECK_EN`, store to 0x42 → `align_fault` pulses once; a load from 0x40 returns its prior value.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the memory stage; align_fault only with MEM_STAGE_ALIGN_CHECK_EN
interface mem_stage_if;
  logic [31:0] ALUResult_in;
  logic [31:0] WriteData_in;
  logic [4:0]  WriteReg_in;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        mem_stall;
  logic [31:0] ReadData_out;
  logic [31:0] ALUResult_out;
  logic [4:0]  WriteReg_out;
  logic        RegWrite_out;
  logic        MemtoReg_out;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic        align_fault;
  modport master(output ALUResult_in, WriteData_in, WriteReg_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
                 input mem_stall, ReadData_out, ALUResult_out, WriteReg_out, RegWrite_out, MemtoReg_out, align_fault);
  modport slave(input ALUResult_in, WriteData_in, WriteReg_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
                output mem_stall, ReadData_out, ALUResult_out, WriteReg_out, RegWrite_out, MemtoReg_out, align_fault);
`else
  modport master(output ALUResult_in, WriteData_in, WriteReg_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
                 input mem_stall, ReadData_out, ALUResult_out, WriteReg_out, RegWrite_out, MemtoReg_out);
  modport slave(input ALUResult_in, WriteData_in, WriteReg_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
                output mem_stall, ReadData_out, ALUResult_out, WriteReg_out, RegWrite_out, MemtoReg_out);
`endif
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM stage with multi-cycle word memory and MEM/WB register; MEM_STAGE_ALIGN_CHECK_EN enables misalignment suppression and align_fault
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 2
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   alu_q, alu_d, rd_q, rd_d;
  logic [4:0]    wreg_q, wreg_d;
  logic          regw_q, regw_d, mtr_q, mtr_d;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          memop, store, start, hold, done, misal, we;
  assign idx = bus.ALUResult_in[AW+1:2];
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic unused_bits;
  assign unused_bits = ^bus.ALUResult_in[31:AW+2];
  assign misal = |bus.ALUResult_in[1:0];
  assign fault_d = done & misal;
  assign bus.align_fault = fault_q;
`else
  logic unused_bits;
  assign unused_bits = ^{bus.ALUResult_in[31:AW+2], bus.ALUResult_in[1:0]};
  assign misal = 1'b0;
`endif
  // next-state: stall while the op is still counting, pass the bundle on completion or non-memory ops
  always_comb begin
    memop   = bus.MemRead_in | bus.MemWrite_in;
    store   = bus.MemWrite_in;
    start   = state_q == IDLE && memop && MEM_LATENCY > 1;
    hold    = start || (state_q == BUSY && cnt_q != 4'd0);
    done    = state_q == BUSY ? cnt_q == 4'd0 : memop && MEM_LATENCY == 1;
    we      = done && store && !misal && !reset;
    state_d = start ? BUSY : (state_q == BUSY && cnt_q == 4'd0) ? IDLE : state_q;
    cnt_d   = start ? 4'(MEM_LATENCY - 2) : (state_q == BUSY && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    alu_d   = hold ? alu_q : bus.ALUResult_in;
    wreg_d  = hold ? wreg_q : bus.WriteReg_in;
    regw_d  = hold ? 1'b0 : bus.RegWrite_in && !(done && !store && misal);
    mtr_d   = hold ? 1'b0 : bus.MemtoReg_in;
    rd_d    = hold ? rd_q : (done && !store && !misal) ? mem[idx] : 32'd0;
  end
  // pipeline state and MEM/WB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      alu_q   <= 32'd0;
      rd_q    <= 32'd0;
      wreg_q  <= 5'd0;
      regw_q  <= 1'b0;
      mtr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      wreg_q  <= wreg_d;
      regw_q  <= regw_d;
      mtr_q   <= mtr_d;
    end
  end
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  // one-cycle fault pulse after a misaligned completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else fault_q <= fault_d;
  end
`endif
  // data memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= bus.WriteData_in;
  end
  assign bus.mem_stall     = hold;
  assign bus.ReadData_out  = rd_q;
  assign bus.ALUResult_out = alu_q;
  assign bus.WriteReg_out  = wreg_q;
  assign bus.RegWrite_out  = regw_q;
  assign bus.MemtoReg_out  = mtr_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a transaction-level model
module tb_mem_stage;
  localparam int D = 256;
  localparam int L = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_stage_if bus();
  mem_stage #(.DEPTH_WORDS(D), .MEM_LATENCY(L)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // model: an op is presented for `age` cycles and completes when it reaches L-1
  logic [31:0] mm [int];
  int age = 0;
  int m_idx;
  logic m_op, m_mis;
  logic [31:0] e_alu = 0, e_rd = 0;
  logic [4:0] e_wr = 0;
  logic e_rw = 0, e_mtr = 0, e_flt = 0, rd_known = 1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age = 0; e_alu = 0; e_rd = 0; e_wr = 0; e_rw = 0; e_mtr = 0; e_flt = 0; rd_known = 1;
    end else begin
      m_op = bus.MemRead_in | bus.MemWrite_in;
      m_idx = int'((bus.ALUResult_in >> 2) % D);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      m_mis = bus.ALUResult_in % 4 != 0;
`else
      m_mis = 1'b0;
`endif
      e_flt = 1'b0;
      if (m_op && age < L - 1) begin
        age++; e_rw = 0; e_mtr = 0;
      end else begin
        age = 0;
        e_alu = bus.ALUResult_in; e_wr = bus.WriteReg_in; e_rw = bus.RegWrite_in; e_mtr = bus.MemtoReg_in;
        e_rd = 0; rd_known = 1;
        if (m_op) begin
          e_flt = m_mis;
          if (bus.MemWrite_in) begin
            if (!m_mis) mm[m_idx] = bus.WriteData_in;
          end else if (m_mis) e_rw = 0;
          else if (mm.exists(m_idx)) e_rd = mm[m_idx];
          else rd_known = 0;
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    chk("stall", bus.mem_stall, (bus.MemRead_in | bus.MemWrite_in) && age < L - 1);
    chk("alu_out", bus.ALUResult_out, e_alu);
    chk("wreg_out", bus.WriteReg_out, e_wr);
    chk("regw_out", bus.RegWrite_out, e_rw);
    chk("mtr_out", bus.MemtoReg_out, e_mtr);
    if (rd_known) chk("rd_out", bus.ReadData_out, e_rd);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    chk("align_fault", bus.align_fault, e_flt);
`endif
  end
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] wr, input logic rw, input logic mtr);
    bus.MemRead_in = r; bus.MemWrite_in = w; bus.ALUResult_in = a; bus.WriteData_in = d;
    bus.WriteReg_in = wr; bus.RegWrite_in = rw; bus.MemtoReg_in = mtr;
  endtask
  task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [4:0] wr, input logic rw, input logic mtr, output int stalls);
    drive(r, w, a, d, wr, rw, mtr);
    stalls = 0;
    for (int i = 0; i <= L + 4; i++) begin
      #1;
      if (!bus.mem_stall) begin
        @(posedge clk); @(negedge clk);
        return;
      end
      stalls++;
      @(posedge clk); @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL op_timeout: stall still high after %0d cycles, required low by %0d", stalls, L);
  endtask
  initial begin
    int n;
    logic [31:0] a;
    logic r, w;
    drive(0, 0, 32'h1234, 0, 5'd5, 1, 0);
    repeat (2) @(negedge clk);
    chk("rst_alu", bus.ALUResult_out, 0);
    chk("rst_wreg", bus.WriteReg_out, 0);
    chk("rst_regw", bus.RegWrite_out, 0);
    chk("rst_rd", bus.ReadData_out, 0);
    chk("rst_stall", bus.mem_stall, 0);
    reset = 0;
    @(posedge clk); #1;
    chk("first_alu", bus.ALUResult_out, 32'h1234);
    chk("first_wreg", bus.WriteReg_out, 5);
    chk("first_regw", bus.RegWrite_out, 1);
    @(negedge clk);
    op(0, 1, 32'h80, 32'h0, 0, 0, 0, n);
    op(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, n);
    chk("st_stalls", n, 2);
    op(1, 0, 32'h40, 0, 5'd7, 1, 1, n);
    chk("ld_stalls", n, 2);
    chk("ld_data", bus.ReadData_out, 32'hDEADBEEF);
    chk("ld_mtr", bus.MemtoReg_out, 1);
    chk("ld_wreg", bus.WriteReg_out, 7);
    op(1, 1, 32'h44, 32'h0BADF00D, 5'd3, 0, 0, n);
    chk("rw_store_rd", bus.ReadData_out, 0);
    op(1, 0, 32'h40 + D * 4, 0, 5'd8, 1, 1, n);
    chk("wrap_data", bus.ReadData_out, 32'hDEADBEEF);
    drive(0, 1, 32'h80, 32'h55AA55AA, 5'd9, 0, 0);
    @(posedge clk); @(negedge clk);
    reset = 1;
    #1;
    chk("mid_rst_rd", bus.ReadData_out, 0);
    chk("mid_rst_alu", bus.ALUResult_out, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    @(negedge clk);
    op(1, 0, 32'h80, 0, 5'd4, 1, 1, n);
    chk("discarded_store", bus.ReadData_out, 0);
    op(1, 0, 32'h40, 0, 5'd4, 1, 1, n);
    chk("reload_data", bus.ReadData_out, 32'hDEADBEEF);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    op(0, 1, 32'h42, 32'h12345678, 0, 0, 0, n);
    chk("mis_fault", bus.align_fault, 1);
    op(1, 0, 32'h40, 0, 5'd6, 1, 1, n);
    chk("mis_fault_clr", bus.align_fault, 0);
    chk("mis_prior", bus.ReadData_out, 32'hDEADBEEF);
`endif
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'd0;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 2) == 0);
      op(r, w, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), n);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
